// File: rtl/e_mdu_if.sv
// e_mdu_if: operand/op/result bundle between the E stage and the multiply/divide unit
interface e_mdu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  opMDU;
  logic        start;
  logic        busy;
  logic [31:0] MDUresult;
  modport master (output SrcA, SrcB, opMDU, start, input busy, MDUresult);
  modport slave (input SrcA, SrcB, opMDU, start, output busy, MDUresult);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: fixed-latency multiply/divide unit owning the HI/LO registers
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);
  logic [31:0] hi, lo, a, b, bd;
  logic [3:0] op;
  logic [15:0] cnt;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u, res;
  logic signed [31:0] q_s, r_s;
  logic ovf, wr;
  // result of the latched op; divisor forced to 1 on /0 and on the one signed overflow case
  always_comb begin
    ovf = a == 32'h8000_0000 && b == 32'hffff_ffff;
    bd = b == 32'h0 ? 32'd1 : b;
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'h0, a} * {32'h0, b};
    q_s = $signed(a) / $signed(ovf ? 32'd1 : bd);
    r_s = $signed(a) % $signed(ovf ? 32'd1 : bd);
    res = op == 4'd1 ? prod_s : op == 4'd2 ? prod_u : op == 4'd3 ? {r_s, q_s} : {a % bd, a / bd};
    wr = b != 32'h0 || op <= 4'd2;
  end
  // countdown, commit on expiry, launch/mthi/mtlo only while idle
  always_ff @(posedge clk)
    if (reset) begin
      hi <= '0;
      lo <= '0;
      a <= '0;
      b <= '0;
      op <= '0;
      cnt <= '0;
    end else if (cnt > 16'd1) cnt <= cnt - 16'd1;
    else if (cnt == 16'd1) begin
      cnt <= '0;
      if (wr) {hi, lo} <= res;
    end else if (bus.start) begin
      if (bus.opMDU >= 4'd1 && bus.opMDU <= 4'd4) begin
        a <= bus.SrcA;
        b <= bus.SrcB;
        op <= bus.opMDU;
        cnt <= bus.opMDU <= 4'd2 ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
      end
      if (bus.opMDU == 4'd7) hi <= bus.SrcA;
      if (bus.opMDU == 4'd8) lo <= bus.SrcA;
    end
  assign bus.busy = cnt != 16'd0;
  assign bus.MDUresult = bus.opMDU == 4'd5 ? hi : bus.opMDU == 4'd6 ? lo : 32'h0;
endmodule
